// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and
// an elaboration-time log2 used to size the shift amount and pipeline depth.
package shifter_pkg;

  typedef enum logic [1:0] {
    MODE_SLL  = 2'b00,
    MODE_SRL  = 2'b01,
    MODE_SRA  = 2'b10,
    MODE_ROTL = 2'b11
  } shmode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter stage: conditionally shifts by 2**STAGE according to
// shamt bit STAGE, then registers the beat together with its side-band.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int STAGE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  shmode_e          i_mode,
  input  logic [SHW-1:0]   i_shamt,
  input  logic             i_sign,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output shmode_e          o_mode,
  output logic [SHW-1:0]   o_shamt,
  output logic             o_sign
);

  localparam int AMT = 1 << STAGE;

  logic [WIDTH-1:0] w_shifted;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  shmode_e          r_mode;
  logic [SHW-1:0]   r_shamt;
  logic             r_sign;

  // SRA fills from the operand's original MSB carried alongside the data,
  // because earlier stages may already have rotated/shifted that bit away.
  always_comb begin
    w_shifted = i_data;
    if (i_shamt[STAGE]) begin
      case (i_mode)
        MODE_SLL:  w_shifted = {i_data[WIDTH-AMT-1:0], {AMT{1'b0}}};
        MODE_SRL:  w_shifted = {{AMT{1'b0}}, i_data[WIDTH-1:AMT]};
        MODE_SRA:  w_shifted = {{AMT{i_sign}}, i_data[WIDTH-1:AMT]};
        MODE_ROTL: w_shifted = {i_data[WIDTH-AMT-1:0], i_data[WIDTH-1:WIDTH-AMT]};
        default:   w_shifted = i_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mode  <= MODE_SLL;
      r_shamt <= '0;
      r_sign  <= 1'b0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= w_shifted;
      r_mode  <= i_mode;
      r_shamt <= i_shamt;
      r_sign  <= i_sign;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_mode  = r_mode;
  assign o_shamt = r_shamt;
  assign o_sign  = r_sign;

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROTL), one log2(WIDTH) stage per
// shift-amount bit, with a single global advance enable for back-pressure.
module pipe_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Index 0 is the un-registered input; index g+1 is the output of stage g.
  logic [SHW:0]            w_vld;
  logic [SHW:0][WIDTH-1:0] w_data;
  logic [SHW:0][SHW-1:0]   w_shamt;
  logic [SHW:0]            w_sign;
  shmode_e                 w_mode [SHW+1];
  logic                    w_adv;
  logic                    w_unused_tail;

  // Whole pipe moves in lockstep; only a stalled valid output holds it.
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  assign w_vld[0]   = in_valid;
  assign w_data[0]  = in_data;
  assign w_shamt[0] = in_shamt;
  assign w_sign[0]  = in_data[WIDTH-1];
  assign w_mode[0]  = shmode_e'(in_mode);

  for (genvar g = 0; g < SHW; g++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .STAGE (g)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_adv),
      .i_valid (w_vld[g]),
      .i_data  (w_data[g]),
      .i_mode  (w_mode[g]),
      .i_shamt (w_shamt[g]),
      .i_sign  (w_sign[g]),
      .o_valid (w_vld[g+1]),
      .o_data  (w_data[g+1]),
      .o_mode  (w_mode[g+1]),
      .o_shamt (w_shamt[g+1]),
      .o_sign  (w_sign[g+1])
    );
  end

  assign out_valid = w_vld[SHW];
  assign out_data  = w_data[SHW];

  // Side-band of the last stage has no consumer.
  assign w_unused_tail = ^{w_mode[SHW], w_shamt[SHW], w_sign[SHW]};

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed bench for pipe_shifter at WIDTH=32: reset, latency, modes,
// streaming, stall/back-pressure, bubbles and mid-flight reset.
module tb_pipe_shifter;

  localparam int W  = 32;
  localparam int SW = 5;
  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROTL = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_shamt = '0;
  logic [1:0]    in_mode = 2'b00;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;

  int passed = 0;
  int total  = 0;

  logic [1:0]  m_mode [17] = '{SLL, SRA, SRL, ROTL, SLL, SRL, SRA, ROTL,
                               SRA, SRA, SLL, ROTL, ROTL, SRA, SRL, SLL, SRA};
  logic [31:0] m_data [17] = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h80000001,
                               32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                               32'h70000000, 32'hF0000000, 32'h80000001, 32'h12345678,
                               32'h12345678, 32'h80000000, 32'hFFFFFFFF, 32'hA5A5A5A5,
                               32'hA5A5A5A5};
  logic [4:0]  m_shamt [17] = '{5'd2, 5'd31, 5'd31, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0,
                                5'd4, 5'd4, 5'd31, 5'd8, 5'd31, 5'd5, 5'd16, 5'd3, 5'd7};
  logic [31:0] m_exp [17] = '{32'h00000004, 32'hFFFFFFFF, 32'h00000001, 32'h00000003,
                              32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                              32'h07000000, 32'hFF000000, 32'h80000000, 32'h34567812,
                              32'h091A2B3C, 32'hFC000000, 32'h0000FFFF, 32'h2D2D2D28,
                              32'hFF4B4B4B};
  logic [31:0] b2b_exp [8] = '{32'd1, 32'd4, 32'd12, 32'd32, 32'd80, 32'd192, 32'd448, 32'd1024};
  logic [31:0] st_exp [6]  = '{32'h80000000, 32'h40000000, 32'h20000000,
                               32'h10000000, 32'h08000000, 32'h04000000};

  pipe_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Pushes one beat into an idle pipe; lat counts edges after the accept edge.
  task automatic run_single(input logic [1:0] m, input logic [31:0] d, input logic [4:0] s,
                            output logic [31:0] res, output int lat);
    in_valid = 1'b1; in_mode = m; in_data = d; in_shamt = s; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    res = out_data;
  endtask

  task automatic test_reset();
    logic seen;
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hFFFFFFFF; in_shamt = 5'd0; out_ready = 1'b0;
    tick(); tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 32'h0) $display("FAIL rst_out_data: got %h want 00000000", out_data); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else passed++;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL rst_drop: beat offered in reset emerged (seen=%b want 0)", seen); else passed++;
  endtask

  task automatic test_latency();
    logic [31:0] res;
    int lat;
    do_reset();
    run_single(SLL, 32'h00000001, 5'd2, res, lat);
    total++; if (lat != 4) $display("FAIL latency: got %0d edges after accept want 4", lat); else passed++;
    total++; if (res !== 32'h00000004) $display("FAIL latency_data: got %h want 00000004", res); else passed++;
  endtask

  task automatic test_modes();
    logic [31:0] res;
    int lat;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      run_single(m_mode[i], m_data[i], m_shamt[i], res, lat);
      total++;
      if (res !== m_exp[i] || lat != 4)
        $display("FAIL mode_vec%0d: got %h (lat %0d) want %h (lat 4)", i, res, lat, m_exp[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [$];
    logic bad_rdy;
    int first, last;
    do_reset();
    bad_rdy = 1'b0; first = -1; last = -1;
    for (int c = 0; c < 30; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; in_mode = SLL; in_data = 32'(c + 1); in_shamt = 5'(c);
        if (in_ready !== 1'b1) bad_rdy = 1'b1;
      end else in_valid = 1'b0;
      tick();
      if (out_valid === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        got.push_back(out_data);
      end
    end
    total++; if (bad_rdy !== 1'b0) $display("FAIL b2b_in_ready: dropped low (flag %b want 0)", bad_rdy); else passed++;
    total++; if (got.size() != 8) $display("FAIL b2b_count: got %0d want 8", got.size()); else passed++;
    total++; if (last - first != 7) $display("FAIL b2b_consecutive: span %0d want 7", last - first); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= got.size()) $display("FAIL b2b_data%0d: missing want %h", i, b2b_exp[i]);
      else if (got[i] !== b2b_exp[i]) $display("FAIL b2b_data%0d: got %h want %h", i, got[i], b2b_exp[i]);
      else passed++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] got [$];
    logic [31:0] held;
    logic bad_rdy, bad_stable, released;
    int b, stall_n;
    do_reset();
    out_ready = 1'b0; b = 0; stall_n = 0; held = '0;
    bad_rdy = 1'b0; bad_stable = 1'b0; released = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (!released && out_valid === 1'b1) begin
        if (stall_n == 0) held = out_data;
        else if (out_data !== held) bad_stable = 1'b1;
        if (in_ready !== 1'b0) bad_rdy = 1'b1;
        stall_n++;
        if (stall_n == 4) released = 1'b1;
      end
      out_ready = released;
      in_valid = (b < 6);
      in_mode = SRL; in_data = 32'h80000000; in_shamt = 5'(b);
      #1;
      if (out_valid === 1'b1 && out_ready) got.push_back(out_data);
      if (in_valid && in_ready === 1'b1) b++;
      if (got.size() == 6) break;
      tick();
    end
    in_valid = 1'b0;
    total++; if (stall_n != 4) $display("FAIL stall_cycles: got %0d stalled samples want 4", stall_n); else passed++;
    total++; if (bad_rdy !== 1'b0) $display("FAIL stall_in_ready: high while stalled (flag %b want 0)", bad_rdy); else passed++;
    total++; if (bad_stable !== 1'b0) $display("FAIL stall_stable: out_data changed (flag %b want 0)", bad_stable); else passed++;
    total++; if (got.size() != 6) $display("FAIL stall_count: got %0d want 6", got.size()); else passed++;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= got.size()) $display("FAIL stall_data%0d: missing want %h", i, st_exp[i]);
      else if (got[i] !== st_exp[i]) $display("FAIL stall_data%0d: got %h want %h", i, got[i], st_exp[i]);
      else passed++;
    end
  endtask

  task automatic test_bubbles();
    logic [11:0] vbits;
    logic [31:0] got [$];
    do_reset();
    vbits = '0;
    for (int c = 0; c < 12; c++) begin
      case (c)
        0: begin in_valid = 1'b1; in_mode = ROTL; in_data = 32'hF000000F; in_shamt = 5'd4; end
        2: begin in_valid = 1'b1; in_mode = ROTL; in_data = 32'h12345678; in_shamt = 5'd8; end
        3: begin in_valid = 1'b1; in_mode = SRA;  in_data = 32'h80000000; in_shamt = 5'd1; end
        default: in_valid = 1'b0;
      endcase
      tick();
      vbits[c] = (out_valid === 1'b1);
      if (out_valid === 1'b1) got.push_back(out_data);
    end
    total++; if (vbits !== 12'h0D0) $display("FAIL bubble_pattern: got %h want 0d0", vbits); else passed++;
    total++; if (got.size() < 1 || got[0] !== 32'h000000FF) $display("FAIL bubble_d0: got %h want 000000ff", got.size() > 0 ? got[0] : 32'hx); else passed++;
    total++; if (got.size() < 2 || got[1] !== 32'h34567812) $display("FAIL bubble_d1: got %h want 34567812", got.size() > 1 ? got[1] : 32'hx); else passed++;
    total++; if (got.size() < 3 || got[2] !== 32'hC0000000) $display("FAIL bubble_d2: got %h want c0000000", got.size() > 2 ? got[2] : 32'hx); else passed++;
  endtask

  task automatic test_reset_midflight();
    logic seen;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_mode = SLL; in_data = 32'h00000011; in_shamt = 5'(i);
      tick();
    end
    rst = 1'b1; in_data = 32'h0000FFFF;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 32'h0) $display("FAIL mid_rst_data: got %h want 00000000", out_data); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); else passed++;
    rst = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL mid_rst_stale: stale beat emerged (seen=%b want 0)", seen); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_back_to_back();
    test_stall();
    test_bubbles();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_shifter.md
PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 Parameter: WIDTH, default 32, data width; SHALL be a power of two, 4..64.
REQ-002 Derived localparam: SHW = log2(WIDTH), shift-amount width and pipeline depth; not overridable.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  input  1  input beat present.
REQ-006 Port: in_ready  output  1  block accepts input beat this cycle.
REQ-007 Port: in_data  input  WIDTH  operand.
REQ-008 Port: in_shamt  input  SHW  shift amount, unsigned, 0..WIDTH-1.
REQ-009 Port: in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTL.
REQ-010 Port: out_valid  output  1  result beat present.
REQ-011 Port: out_ready  input  1  consumer accepts result.
REQ-012 Port: out_data  output  WIDTH  shifted result.

Function
REQ-013 Pipeline of SHW stage registers; stage i (0..SHW-1) applies shift by 2^i when its shamt bit i is 1, else passes data unchanged.
REQ-014 Each stage register holds valid, data, mode, shamt; no combinational path from in_data to out_data.
REQ-015 Advance enable adv = ~out_valid | out_ready; in_ready = adv; whole pipeline moves together when adv=1, holds all stages when adv=0.
REQ-016 Input beat accepted on rising edge where in_valid & in_ready; in_data/in_shamt/in_mode ignored otherwise.
REQ-017 Latency: beat accepted at edge k appears on out_data with out_valid=1 after edge k+SHW-1 (SHW cycles, 5 for WIDTH=32) if no stall.
REQ-018 Throughput: one beat per cycle with out_ready held 1; bubbles (in_valid=0) propagate as valid=0 slots, not collapsed.
REQ-019 SLL: zero fill from LSB; SRL: zero fill from MSB; SRA: fill with operand's original bit WIDTH-1; ROTL: bits leaving MSB re-enter at LSB.
REQ-020 shamt=0 SHALL return in_data unchanged for all modes.
REQ-021 Result is exact WIDTH bits; no overflow/carry output; shifted-out bits discarded (except ROTL).
REQ-022 While out_valid=1 and out_ready=0, out_data SHALL stay stable and no beat is lost or duplicated.
REQ-023 Simultaneous output pop and input push in same cycle SHALL both take effect.
REQ-024 Stage data of invalid slots is don't-care but SHALL not be X-propagating after reset (cleared to 0).

Reset
REQ-025 rst=1 at a rising edge clears every stage valid, data, mode and shamt to 0; out_valid=0, out_data=0 the following cycle.
REQ-026 Reset mid-operation discards all in-flight beats; no beat emerges after reset deasserts unless accepted afterwards.
REQ-027 in_ready = 1 during and immediately after reset (out_valid=0 implies adv=1); beats offered while rst=1 SHALL be dropped.

Structure
REQ-028 Shared package shifter_pkg holds mode encoding constants (SLL/SRL/SRA/ROTL) and a clog2 constant function.
REQ-029 One sub-module shift_stage, parametrised by WIDTH and stage index, implements one conditional 2^i shift plus its register; pipe_shifter instantiates SHW copies via generate.
REQ-030 SRA sign bit carried explicitly per stage (not re-derived from shifted data).

Verification
REQ-031 WIDTH=32, SLL, data 0x00000001, shamt 2, out_ready=1 -> out_data 0x00000004, out_valid exactly 5 cycles after accept.
REQ-032 SRA 0x80000000 shamt 31 -> 0xFFFFFFFF; SRL same operands -> 0x00000001; ROTL 0x80000001 shamt 1 -> 0x00000003.
REQ-033 Back-to-back 8 beats, out_ready=1 -> 8 results in order on 8 consecutive cycles, in_ready constantly 1.
REQ-034 Pipeline full, out_ready=0 for 4 cycles -> in_ready=0, out_data stable; release -> all beats in order, none lost/duplicated.
REQ-035 rst=1 with 3 beats in flight -> out_valid=0 next cycle; no stale result afterwards.
REQ-036 Random mode/shamt/data, 10k beats with random in_valid/out_ready, WIDTH in {8,32,64} -> matches reference model in order.
